ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- AHB-Lite slave that sits directly downstream of the pipelined RV32I core's AHB master port and serves both instruction fetches and data load/store traffic from on-chip SRAM.
- Implements address/data phase pipelining, a configurable number of wait states, byte/halfword/word lane writes, and the two-cycle ERROR response for illegal transfers.
- Connects to the bus through a decoder-driven HSEL.

Parameters:
- MEM_BYTES, 4096: SRAM size in bytes; must be a power of two and at least 4.
- BASE_ADDR, 32'h0000_0000: byte address mapped to SRAM offset 0.
- WAIT_STATES, 0: number of HREADYOUT-low cycles inserted in every OKAY data phase (0..15).
- INIT_FILE, "": hex image loaded with $readmemh at elaboration when the string is non-empty.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- HSEL  in  1  slave select from the address decoder
- HADDR  in  32  transfer byte address
- HTRANS  in  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWRITE  in  1  1 = write, 0 = read
- HSIZE  in  3  transfer size: 0 = byte, 1 = halfword, 2 = word
- HBURST  in  3  burst type; ignored, each beat is handled independently
- HPROT  in  4  protection control; ignored
- HMASTLOCK  in  1  locked transfer; ignored
- HWDATA  in  32  write data for the current data phase
- HREADY  in  1  bus-level ready (combined HREADY of all slaves)
- HREADYOUT  out  1  this slave's ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  32  read data

Behaviour:
- Reset (asynchronous, reset_n=0):
  - FSM returns to IDLE, HREADYOUT=1, HRESP=0, HRDATA=0.
  - All captured address-phase registers are cleared.
  - SRAM contents are not reset.
  - Reset asserted in the middle of a data phase aborts the transfer; no write is committed.
- Address phase acceptance:
  - A transfer is accepted when HSEL && HREADY && HTRANS[1] are all high at a rising edge.
  - On acceptance, register HADDR, HWRITE and HSIZE, and set a pending flag.
  - IDLE or BUSY beats, or HSEL=0, get a zero-wait OKAY (HREADYOUT=1, HRESP=0).
- Legality check (done at acceptance); a transfer is illegal if any of these hold:
  - HSIZE > 2;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0]!=0;
  - (HADDR - BASE_ADDR) >= MEM_BYTES (unsigned 32-bit compare).
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE, accepted legal transfer with WAIT_STATES=0: stay IDLE; data phase completes next cycle with HREADYOUT=1.
  - IDLE, accepted legal transfer with WAIT_STATES>0: go to WAIT; load counter = WAIT_STATES-1; HREADYOUT=0.
  - WAIT: decrement the counter each cycle; at 0 drive HREADYOUT=1 and return to IDLE. A new transfer accepted on that completing edge re-enters WAIT.
  - IDLE, accepted illegal transfer: go to ERR1.
  - ERR1: HRESP=1, HREADYOUT=0; next state ERR2.
  - ERR2: HRESP=1, HREADYOUT=1; next state IDLE, or accept a new transfer on this edge if one is presented.
  - The master may drive HTRANS=IDLE during ERR2 to cancel a burst; no special handling is needed.
- Writes:
  - Byte lanes are little-endian, selected by the registered HSIZE and HADDR[1:0].
  - HWDATA is sampled, and the selected lanes are written, only on the edge that ends the data phase (HREADYOUT=1, legal transfer).
  - Illegal transfers never modify SRAM.
- Reads:
  - HRDATA returns the full 32-bit word at offset[ADDR_BITS-1:2].
  - HRDATA is valid only in the cycle where HREADYOUT=1 ends a read data phase; it is 0 otherwise, including during ERR1 and ERR2.
- Write followed by read:
  - A write to address A immediately followed by a read of A returns the new data.
  - This holds because the write commits on the edge that ends its data phase, before the read's data phase.
- Widths: ADDR_BITS = $clog2(MEM_BYTES); the word index is offset[ADDR_BITS-1:2].

Decomposition:
- Shared include ahb_defs.vh holds:
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ);
  - HSIZE codes (BYTE, HALF, WORD);
  - HRESP codes (OKAY, ERROR);
  - FSM state encodings.
- Sub-module ahb_bytelane_gen: combinational block taking HSIZE and addr[1:0] and producing a 4-bit byte enable plus a misaligned flag. The same block is reused later by the core's MEM stage.

Test Plan:
- Word write 0xDEADBEEF to 0x10 with WAIT_STATES=0, then read 0x10 → one-cycle data phases, HRDATA=0xDEADBEEF, HRESP=0.
- Byte write 0xAA to 0x13 over prior word 0x11223344 at 0x10 → word read returns 0xAA223344.
- WAIT_STATES=2: read of 0x20 → HREADYOUT low for exactly 2 cycles, then high with data.
- Halfword read at 0x21 → ERR1 (HRESP=1, HREADYOUT=0) then ERR2 (HRESP=1, HREADYOUT=1); a write at 0x21 must leave SRAM unchanged.
- Access at BASE_ADDR+MEM_BYTES (0x1000) → two-cycle ERROR; the next NONSEQ read at 0x0 is accepted during ERR2 and returns OKAY.
- reset_n pulsed low during a WAIT-state write → HREADYOUT=1, HRESP=0, target word unchanged.

Source files
------------

// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite encodings, FSM states and captured-request layout for the SRAM slave.
package ahb_sram_slave_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0]          offs;
    logic                 write;
    logic [2:0]           size;
    logic [NUM_LANES-1:0] be;
  } req_t;

endpackage

// File: rtl/ahb_bytelane_gen.sv
// Byte-enable and alignment decode from transfer size and low address bits (little-endian).
module ahb_bytelane_gen
  import ahb_sram_slave_pkg::*;
(
  input  logic [2:0]           size,
  input  logic [1:0]           addr,
  output logic [NUM_LANES-1:0] be,
  output logic                 misaligned
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam logic [1:0] LI = 2'(l);
    assign be[l] = (size == HSIZE_WORD) ||
                   (size == HSIZE_HALF && addr[1] == LI[1]) ||
                   (size == HSIZE_BYTE && addr == LI);
  end

  // Unsupported sizes yield no lanes; the caller flags them separately.
  assign misaligned = (size == HSIZE_HALF && addr[0]) ||
                      (size == HSIZE_WORD && addr != 2'b00);

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: pipelined address/data phases, optional wait states, two-cycle ERROR.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int ADDR_BITS = $clog2(MEM_BYTES);
  localparam int IDX_W     = (ADDR_BITS > 2) ? ADDR_BITS - 2 : 1;
  localparam int WORDS     = MEM_BYTES / 4;
  localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  state_t               state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  req_t                 req_q;
  logic                 pend_q;
  logic [31:0]          offs;
  logic [NUM_LANES-1:0] be;
  logic                 misaligned;
  logic                 ready, accept, illegal, done;
  logic [IDX_W-1:0]     widx;

  logic [NUM_LANES-1:0][7:0] mem [WORDS];

  ahb_bytelane_gen u_lane (
    .size       (HSIZE),
    .addr       (HADDR[1:0]),
    .be         (be),
    .misaligned (misaligned)
  );

  assign offs    = HADDR - BASE_ADDR;
  assign ready   = (state == ST_IDLE) || (state == ST_ERR2);
  assign accept  = ready && HSEL && HREADY && HTRANS[1];
  assign illegal = (HSIZE > HSIZE_WORD) || misaligned || (offs >= 32'(MEM_BYTES));
  // Wait cycles are spent in ST_WAIT; the data phase always completes in ST_IDLE.
  assign done    = pend_q && (state == ST_IDLE);
  assign widx    = IDX_W'(req_q.offs >> 2);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_WAIT: begin
        if (cnt == 4'd0) state_nxt = ST_IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: begin
        state_nxt = ST_IDLE;
        if (accept) begin
          if (illegal) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WS_LOAD;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      pend_q <= 1'b0;
      req_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (ready) begin
        pend_q <= accept && !illegal;
        if (accept) req_q <= '{offs: offs, write: HWRITE, size: HSIZE, be: be};
      end
    end
  end

  // SRAM array is never reset; pend_q clears asynchronously so a reset aborts the write.
  always_ff @(posedge clk) begin
    if (done && req_q.write && reset_n) begin
      for (int l = 0; l < NUM_LANES; l++)
        if (req_q.be[l]) mem[widx][l] <= HWDATA[8*l +: 8];
    end
  end

  assign HREADYOUT = ready;
  assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = (done && !req_q.write) ? 32'(mem[widx]) : 32'h0;

  logic unused;
  assign unused = ^{HBURST, HPROT, HMASTLOCK, req_q.offs, req_q.size};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: zero-wait and two-wait-state instances sharing one master-side stimulus.
module tb_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sel0, sel2;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        rdy0, resp0, rdy2, resp2;
  logic [31:0] rdata0, rdata2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ahb_sram_slave #(.WAIT_STATES(0)) u0 (
    .clk(clk), .reset_n(reset_n), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'd0), .HMASTLOCK(1'b0),
    .HWDATA(hwdata), .HREADY(rdy0), .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0)
  );

  ahb_sram_slave #(.WAIT_STATES(2)) u2 (
    .clk(clk), .reset_n(reset_n), .HSEL(sel2), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'd0), .HMASTLOCK(1'b0),
    .HWDATA(hwdata), .HREADY(rdy2), .HREADYOUT(rdy2), .HRESP(resp2), .HRDATA(rdata2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_ph(input logic [31:0] a, input logic w, input logic [2:0] s);
    haddr  = a;
    hwrite = w;
    hsize  = s;
    htrans = 2'd2;
  endtask

  task automatic idle_ph();
    htrans = 2'd0;
    hwrite = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; sel0 = 1'b0; sel2 = 1'b0;
    haddr = '0; htrans = 2'd0; hwrite = 1'b0; hsize = 3'd2; hwdata = '0;
    #2;
    chk("rst_rdy0", rdy0, 1'b1);
    chk("rst_resp0", resp0, 1'b0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdy2", rdy2, 1'b1);
    chk("rst_resp2", resp2, 1'b0);
    chk("rst_rdata2", rdata2, 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    sel0 = 1'b1;

    // zero-wait word write/read with back-to-back write then read of the same address
    addr_ph(32'h0, 1'b1, 3'd2);
    tick(); hwdata = 32'h0BAD_F00D; addr_ph(32'h10, 1'b1, 3'd2);
    #2 chk("w0_rdy", rdy0, 1'b1);
    tick(); hwdata = 32'hDEAD_BEEF; addr_ph(32'h10, 1'b0, 3'd2);
    #2 chk("w10_rdy", rdy0, 1'b1);
    chk("w10_resp", resp0, 1'b0);
    chk("w10_rdata_zero", rdata0, 32'h0);
    tick(); hwdata = 32'h0; idle_ph();
    #2 chk("r10_data", rdata0, 32'hDEAD_BEEF);
    chk("r10_rdy", rdy0, 1'b1);
    chk("r10_resp", resp0, 1'b0);
    tick();
    #2 chk("idle_rdata", rdata0, 32'h0);

    // byte lane 3 then halfword upper lanes over a known word
    addr_ph(32'h10, 1'b1, 3'd2);
    tick(); hwdata = 32'h1122_3344; addr_ph(32'h13, 1'b1, 3'd0);
    tick(); hwdata = 32'hAA55_6677; addr_ph(32'h10, 1'b0, 3'd2);
    tick(); idle_ph();
    #2 chk("byte_wr", rdata0, 32'hAA22_3344);
    addr_ph(32'h12, 1'b1, 3'd1);
    tick(); hwdata = 32'h5A5A_9999; addr_ph(32'h10, 1'b0, 3'd2);
    tick(); idle_ph();
    #2 chk("half_wr", rdata0, 32'h5A5A_3344);

    // misaligned halfword read and write at 0x21
    addr_ph(32'h20, 1'b1, 3'd2);
    tick(); hwdata = 32'hCAFE_F00D; addr_ph(32'h21, 1'b0, 3'd1);
    tick(); idle_ph();
    #2 chk("mis_r_err1_resp", resp0, 1'b1);
    chk("mis_r_err1_rdy", rdy0, 1'b0);
    chk("mis_r_err1_rdata", rdata0, 32'h0);
    tick(); addr_ph(32'h21, 1'b1, 3'd1);
    #2 chk("mis_r_err2_resp", resp0, 1'b1);
    chk("mis_r_err2_rdy", rdy0, 1'b1);
    chk("mis_r_err2_rdata", rdata0, 32'h0);
    tick(); hwdata = 32'hFFFF_FFFF; idle_ph();
    #2 chk("mis_w_err1_resp", resp0, 1'b1);
    chk("mis_w_err1_rdy", rdy0, 1'b0);
    tick(); addr_ph(32'h20, 1'b0, 3'd2);
    #2 chk("mis_w_err2_resp", resp0, 1'b1);
    chk("mis_w_err2_rdy", rdy0, 1'b1);
    tick(); idle_ph();
    #2 chk("mis_w_unchanged", rdata0, 32'hCAFE_F00D);
    chk("mis_w_resp_ok", resp0, 1'b0);

    // out of range, next read accepted during ERR2
    tick(); addr_ph(32'h1000, 1'b0, 3'd2);
    tick(); idle_ph();
    #2 chk("oor_err1_resp", resp0, 1'b1);
    chk("oor_err1_rdy", rdy0, 1'b0);
    tick(); addr_ph(32'h0, 1'b0, 3'd2);
    #2 chk("oor_err2_resp", resp0, 1'b1);
    chk("oor_err2_rdy", rdy0, 1'b1);
    tick(); idle_ph();
    #2 chk("oor_next_data", rdata0, 32'h0BAD_F00D);
    chk("oor_next_resp", resp0, 1'b0);
    chk("oor_next_rdy", rdy0, 1'b1);
    tick();

    // two wait states on the second instance
    sel0 = 1'b0; sel2 = 1'b1;
    addr_ph(32'h20, 1'b1, 3'd2);
    tick(); hwdata = 32'h1234_5678; idle_ph();
    #2 chk("ws_w_c1", rdy2, 1'b0);
    chk("ws_u0_unsel", rdy0, 1'b1);
    tick();
    #2 chk("ws_w_c2", rdy2, 1'b0);
    tick();
    #2 chk("ws_w_c3", rdy2, 1'b1);
    chk("ws_w_resp", resp2, 1'b0);
    tick(); addr_ph(32'h20, 1'b0, 3'd2);
    tick(); idle_ph();
    #2 chk("ws_r_c1_rdy", rdy2, 1'b0);
    chk("ws_r_c1_rdata", rdata2, 32'h0);
    tick();
    #2 chk("ws_r_c2_rdy", rdy2, 1'b0);
    tick();
    #2 chk("ws_r_c3_rdy", rdy2, 1'b1);
    chk("ws_r_c3_data", rdata2, 32'h1234_5678);
    chk("ws_r_c3_resp", resp2, 1'b0);
    tick();
    #2 chk("ws_r_after", rdata2, 32'h0);

    // reset in the middle of a waited write aborts it
    addr_ph(32'h20, 1'b1, 3'd2);
    tick(); hwdata = 32'hFFFF_FFFF; idle_ph();
    #2 chk("rstw_wait", rdy2, 1'b0);
    reset_n = 1'b0;
    #1 chk("rstw_rdy", rdy2, 1'b1);
    chk("rstw_resp", resp2, 1'b0);
    tick(); reset_n = 1'b1;
    tick(); addr_ph(32'h20, 1'b0, 3'd2);
    tick(); idle_ph();
    tick(); tick();
    #2 chk("rstw_unchanged", rdata2, 32'h1234_5678);
    chk("rstw_rd_rdy", rdy2, 1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
